// File: rtl/gray_conv_arbiter_if.sv
// gray_conv_arbiter_if: request/result bus between the conversion users and the
// gray_conv_arbiter. The master side drives the requests and res_ready. The slave
// side (the arbiter) drives req_ready and the result register.
// Optional macro GRAY_DIR_EN adds req_dir (per-requester direction) and res_dir.
interface gray_conv_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W     = 4
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               res_valid;
  logic [W-1:0]       res_gray;
  logic [IDW-1:0]     res_id;
  logic               res_ready;
`ifdef GRAY_DIR_EN
  logic [N_REQ-1:0]   req_dir;
  logic               res_dir;
`endif

`ifdef GRAY_DIR_EN
  modport master (
    output req_valid, req_data, req_dir, res_ready,
    input  req_ready, res_valid, res_gray, res_id, res_dir
  );

  modport slave (
    input  req_valid, req_data, req_dir, res_ready,
    output req_ready, res_valid, res_gray, res_id, res_dir
  );
`else
  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_gray, res_id
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_gray, res_id
  );
`endif
endinterface

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin arbiter that shares one binary-to-Gray converter
// among N_REQ requesters. The converted word is held in a one-entry output register
// that has its own valid/ready handshake. A held result can drain and a new one can
// load in the same cycle, so the block sustains one result per cycle.
// Optional macro GRAY_DIR_EN: a per-requester req_dir bit selects the Gray-to-binary
// direction, and res_dir is registered alongside the result.
module gray_conv_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  gray_conv_arbiter_if.slave bus
);
  localparam int IDW = $clog2(N_REQ);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q;
  logic             resValid_q;
  logic [W-1:0]     resGray_q;
  logic [IDW-1:0]   resId_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   ptr_d;

  logic             slotFree;
  logic             grantHit;
  logic [IDW-1:0]   grantIdx;
  logic             transfer;
  logic [N_REQ-1:0] reqReady;
  logic [W-1:0]     selWord;
  logic [W-1:0]     convWord;
  int               scanIdx;

`ifdef GRAY_DIR_EN
  logic             resDir_q;
  logic             selDir;
`endif

  function automatic logic [W-1:0] binToGray(input logic [W-1:0] b);
    logic [W-1:0] g;
    g[W-1] = b[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      g[i] = b[i+1] ^ b[i];
    end
    return g;
  endfunction

`ifdef GRAY_DIR_EN
  function automatic logic [W-1:0] grayToBin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction
`endif

  // The output slot can accept a new word when it is empty or is draining this cycle.
  assign slotFree = (state_q == EMPTY) || bus.res_ready;

  // Round-robin scan that starts at ptr and wraps at N_REQ-1, so the first valid requester wins.
  always_comb begin
    grantHit = 1'b0;
    grantIdx = '0;
    scanIdx  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scanIdx = int'(ptr_q) + k;
      if (scanIdx >= N_REQ) begin
        scanIdx = scanIdx - N_REQ;
      end
      if (!grantHit && bus.req_valid[scanIdx]) begin
        grantHit = 1'b1;
        grantIdx = IDW'(scanIdx);
      end
    end
  end

  // A grant only counts while out of reset, so no handshake completes while rst_n is low.
  assign transfer = slotFree && grantHit && rst_n;

  // req_ready is one-hot on the granted requester and all zero otherwise.
  always_comb begin
    reqReady = '0;
    if (transfer) begin
      reqReady[grantIdx] = 1'b1;
    end
  end

  assign bus.req_ready = reqReady;

  // Steer the granted requester's word (and direction) into the shared converter.
  always_comb begin
    selWord = '0;
`ifdef GRAY_DIR_EN
    selDir  = 1'b0;
`endif
    for (int i = 0; i < N_REQ; i++) begin
      if (grantIdx == IDW'(i)) begin
        selWord = bus.req_data[i*W +: W];
`ifdef GRAY_DIR_EN
        selDir  = bus.req_dir[i];
`endif
      end
    end
  end

  // Shared conversion datapath: binary-to-Gray, or Gray-to-binary when the requester asks for it.
  always_comb begin
`ifdef GRAY_DIR_EN
    convWord = selDir ? grayToBin(selWord) : binToGray(selWord);
`else
    convWord = binToGray(selWord);
`endif
  end

  // The pointer moves to the requester after the one just served, and wraps to 0 after the last.
  always_comb begin
    if (grantIdx == IDW'(N_REQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = grantIdx + IDW'(1);
    end
  end

  // Output-slot FSM: load on transfer, drain on res_ready, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      resValid_q <= 1'b0;
      resGray_q  <= '0;
      resId_q    <= '0;
      ptr_q      <= '0;
`ifdef GRAY_DIR_EN
      resDir_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (transfer) begin
            state_q    <= FULL;
            resValid_q <= 1'b1;
          end
        end
        FULL: begin
          if (bus.res_ready && !transfer) begin
            state_q    <= EMPTY;
            resValid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= EMPTY;
          resValid_q <= 1'b0;
        end
      endcase
      if (transfer) begin
        resGray_q <= convWord;
        resId_q   <= grantIdx;
        ptr_q     <= ptr_d;
`ifdef GRAY_DIR_EN
        resDir_q  <= selDir;
`endif
      end
    end
  end

  assign bus.res_valid = resValid_q;
  assign bus.res_gray  = resGray_q;
  assign bus.res_id    = resId_q;
`ifdef GRAY_DIR_EN
  assign bus.res_dir   = resDir_q;
`endif

  // Structural invariants: at most one grant, and the held result is frozen under backpressure.
  aReadyOneHot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.req_ready));

  aHoldStable: assert property (@(posedge clk) disable iff (!rst_n)
    (resValid_q && !bus.res_ready) |=> ($stable(resGray_q) && $stable(resId_q) && resValid_q));

  aNoGrantWhenBlocked: assert property (@(posedge clk) disable iff (!rst_n)
    (resValid_q && !bus.res_ready) |-> (bus.req_ready == '0));

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter: scoreboard bench for gray_conv_arbiter. A round-robin
// reference model predicts req_ready every cycle and queues the expected result of
// every transfer. A separate monitor pops and compares whenever a result drains.
// Build with GRAY_DIR_EN defined to exercise the direction-select feature as well.
module tb_gray_conv_arbiter;
  localparam int N   = 4;
  localparam int W   = 4;
  localparam int IDW = $clog2(N);

  typedef struct {
    logic [W-1:0] val;
    int           id;
    bit           dir;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  exp_t         sb[$];
  int           mPtr = 0;
  bit           mFull = 1'b0;
  logic [N-1:0] accepted = '0;

  int expSeq[6] = '{0, 1, 2, 3, 0, 1};

  gray_conv_arbiter_if #(.N_REQ(N), .W(W)) bus ();

  gray_conv_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Gray code built bit by bit from its definition.
  function automatic logic [W-1:0] refGray(input logic [W-1:0] b);
    logic [W-1:0] g;
    g[W-1] = b[W-1];
    for (int i = 0; i < W - 1; i++) g[i] = b[i+1] ^ b[i];
    return g;
  endfunction

  // Inverse Gray found by searching for the binary word whose Gray code matches.
  function automatic logic [W-1:0] refUngray(input logic [W-1:0] g);
    for (int c = 0; c < (1 << W); c++) begin
      if (refGray(W'(c)) == g) return W'(c);
    end
    return '0;
  endfunction

  // Reference model for one cycle, evaluated mid-cycle once the inputs have settled.
  task automatic checkOutput();
    int           g;
    bit           free;
    logic [N-1:0] expReady;
    logic [W-1:0] d;
    exp_t         e;
    accepted = '0;
    g        = -1;
    expReady = '0;
    free     = !mFull || bus.res_ready;
    if (free) begin
      for (int k = 0; k < N; k++) begin
        int idx = (mPtr + k) % N;
        if (g < 0 && bus.req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) expReady[g] = 1'b1;
    checkEq("req_ready", 32'(bus.req_ready), 32'(expReady));
    checkEq("res_valid", 32'(bus.res_valid), 32'(mFull));
    if (g >= 0) begin
      d     = bus.req_data[g*W +: W];
      e.id  = g;
      e.dir = 1'b0;
`ifdef GRAY_DIR_EN
      e.dir = bus.req_dir[g];
`endif
      e.val = e.dir ? refUngray(d) : refGray(d);
      sb.push_back(e);
      accepted[g] = 1'b1;
      mPtr  = (g + 1) % N;
      mFull = 1'b1;
    end else if (bus.res_ready) begin
      mFull = 1'b0;
    end
  endtask

  // Random requesters: a pending request keeps its word until accepted, then may be replaced.
  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      if (!bus.req_valid[i] || accepted[i]) begin
        bus.req_valid[i]          = ($urandom_range(0, 99) < 55);
        bus.req_data[i*W +: W]    = W'($urandom);
`ifdef GRAY_DIR_EN
        bus.req_dir[i]            = 1'($urandom_range(0, 1));
`endif
      end
    end
    bus.res_ready = ($urandom_range(0, 99) < 70);
  endtask

  task automatic toNeg();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic toPos();
    @(posedge clk);
    #1;
  endtask

  // Result monitor: compare the held result with the oldest expected entry, and pop it on drain.
  always @(negedge clk) begin
    if (rst_n && bus.res_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result actual=id %0d expected=no pending result", bus.res_id);
      end else begin
        checkEq("res_gray", 32'(bus.res_gray), 32'(sb[0].val));
        checkEq("res_id", 32'(bus.res_id), 32'(sb[0].id));
`ifdef GRAY_DIR_EN
        checkEq("res_dir", 32'(bus.res_dir), 32'(sb[0].dir));
`endif
        if (bus.res_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b0;
`ifdef GRAY_DIR_EN
    bus.req_dir   = '0;
`endif
    rst_n = 1'b0;
    $display("[TB] start");

    // Power-on reset: outputs cleared and no grant even with requests pending.
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = 4'b1111;
    #2;
    checkEq("reset_res_valid", 32'(bus.res_valid), 32'd0);
    checkEq("reset_res_gray", 32'(bus.res_gray), 32'd0);
    checkEq("reset_res_id", 32'(bus.res_id), 32'd0);
    checkEq("reset_req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    rst_n = 1'b1;

    // Single request from requester 0.
    bus.req_valid         = 4'b0001;
    bus.req_data[3:0]     = 4'b1011;
    bus.res_ready         = 1'b1;
    toNeg();
    checkEq("single_req_ready", 32'(bus.req_ready), 32'b0001);
    toPos();
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    toNeg();
    checkEq("single_res_valid", 32'(bus.res_valid), 32'd1);
    checkEq("single_res_gray", 32'(bus.res_gray), 32'b1110);
    checkEq("single_res_id", 32'(bus.res_id), 32'd0);

    // Asynchronous reset while a result is held.
    bus.req_valid = 4'b1111;
    bus.req_data  = 16'($urandom);
    #2;
    rst_n = 1'b0;
    #1;
    checkEq("midreset_res_valid", 32'(bus.res_valid), 32'd0);
    checkEq("midreset_res_gray", 32'(bus.res_gray), 32'd0);
    checkEq("midreset_req_ready", 32'(bus.req_ready), 32'd0);
    sb.delete();
    mFull = 1'b0;
    mPtr  = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.res_ready = 1'b1;

    // Full contention with a draining consumer: back-to-back grants in rotation from 0.
    for (int c = 0; c < 6; c++) begin
      toNeg();
      checkEq("contention_grant", 32'(bus.req_ready), 32'(1) << expSeq[c]);
      toPos();
    end

    // Park ptr at 1 by serving requester 0, then apply backpressure.
    bus.req_valid      = 4'b0001;
    bus.req_data[3:0]  = 4'b1000;
    bus.res_ready      = 1'b1;
    toNeg();
    toPos();
    bus.req_valid      = 4'b0110;
    bus.req_data[7:4]  = 4'b1111;
    bus.req_data[11:8] = 4'b0000;
    bus.res_ready      = 1'b0;
    for (int c = 0; c < 3; c++) begin
      toNeg();
      checkEq("bp_req_ready", 32'(bus.req_ready), 32'd0);
      checkEq("bp_res_gray", 32'(bus.res_gray), 32'b1100);
      checkEq("bp_res_id", 32'(bus.res_id), 32'd0);
      toPos();
    end
    bus.res_ready = 1'b1;
    toNeg();
    checkEq("bp_release_grant", 32'(bus.req_ready), 32'b0010);
    toPos();
    bus.req_valid = 4'b0100;
    toNeg();
    checkEq("bp_next_grant", 32'(bus.req_ready), 32'b0100);
    checkEq("boundary_1111", 32'(bus.res_gray), 32'b1000);
    checkEq("boundary_1111_id", 32'(bus.res_id), 32'd1);
    toPos();
    bus.req_valid = '0;
    toNeg();
    checkEq("boundary_0000", 32'(bus.res_gray), 32'b0000);
    checkEq("boundary_0000_id", 32'(bus.res_id), 32'd2);
    toPos();

`ifdef GRAY_DIR_EN
    // Gray-to-binary request from requester 3.
    bus.req_valid       = 4'b1000;
    bus.req_data[15:12] = 4'b1110;
    bus.req_dir         = 4'b1000;
    toNeg();
    toPos();
    bus.req_valid = '0;
    bus.req_dir   = '0;
    toNeg();
    checkEq("dir_res_gray", 32'(bus.res_gray), 32'b1011);
    checkEq("dir_res_dir", 32'(bus.res_dir), 32'd1);
    checkEq("dir_res_id", 32'(bus.res_id), 32'd3);
    toPos();
`endif

    // Randomized traffic with random backpressure.
    accepted = '0;
    repeat (3000) begin
      applyStimulus();
      toNeg();
      toPos();
    end

    // Drain everything and confirm nothing expected is left outstanding.
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    repeat (4) begin
      toNeg();
      toPos();
    end
    checkEq("drain_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
